pipe_ex: RTL and testbench
==========================

Name: pipe_ex

Overview:
- Execute stage of the in-order pipeline.
- Accepts one uop from decode under a valid/ready handshake and computes ALU results.
- Runs loads and stores through a blocking single-outstanding memory port.
- Drives the ex→wb valid/ready interface (exToWb_t) and an ex-stage forwarding port.

Parameters:
- XLEN, 32, data/address width (ele_t width).

Ports:
- clk_i  in  1  clock, all state on rising edge
- rst_ni  in  1  asynchronous active-low reset
- idToEx_i  in  idToEx_t  uop_info (pc, inst, rd, rd_wen, fu_op ALU/LOAD/STORE, alu_op[3:0], ebreak), opa, opb, st_data
- id_valid_i  in  1  decode offers a uop
- ex_ready_o  out  1  ex accepts the uop this cycle
- exToWb_o  out  exToWb_t  uop_info, alu_res, lsu_res
- ex_valid_o  out  1  exToWb_o valid
- wb_ready_i  in  1  wb accepts exToWb_o
- mem_req_valid_o  out  1  memory request valid
- mem_req_ready_i  in  1  memory accepts request
- mem_req_we_o  out  1  1 = store
- mem_req_addr_o  out  XLEN  word-aligned address ({addr[31:2],2'b00})
- mem_req_wdata_o  out  XLEN  lane-shifted store data
- mem_req_wstrb_o  out  4  byte strobes
- mem_rsp_valid_i  in  1  load data return (loads only)
- mem_rsp_rdata_i  in  XLEN  aligned load word
- ex_fwd_valid_o  out  1  ex_valid_o && uop_info.rd_wen
- ex_fwd_rd_o  out  5  rd of output uop
- ex_fwd_data_o  out  XLEN  rd value of output uop (lsu_res for LOAD, else alu_res)
- ex_fwd_pending_o  out  1  load with rd_wen in flight; rd value not yet available

Behaviour:
- Reset values: state IDLE, ex_valid_o=0, mem_req_valid_o=0, ex_fwd_valid_o=0, ex_fwd_pending_o=0, exToWb_o=0.
- Reset mid-operation aborts any access. mem_rsp_valid_i is ignored unless state is WAIT_RSP.
- out_free = !ex_valid_o || wb_ready_i.
- ex_ready_o = (state==IDLE) && out_free.
- Accept fires when id_valid_i && ex_ready_o. The accepted uop is latched into a uop register.
- ALU ops, opb shift amount is opb[4:0]: 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND. Codes 10-15 yield 0.
- LOAD and STORE use ADD to form the address in alu_res.
- fu_op ALU path: exToWb_o is registered on the accept edge, so ex_valid_o=1 the next cycle (latency 1). State stays IDLE, giving back-to-back throughput of 1 uop/cycle.
- fu_op LOAD/STORE path: on accept go to REQ.
- REQ state:
  - mem_req_valid_o=1; address, we, wdata and wstrb are held stable until mem_req_ready_i.
  - On a store handshake: go to IDLE and load the output register the same edge (ex_valid_o next cycle).
  - On a load handshake: go to WAIT_RSP.
- WAIT_RSP state: on mem_rsp_valid_i, extract and extend the load data into lsu_res, load the output register, go to IDLE.
- Output load rule: the output register only loads when out_free. A store handshake or load response is guaranteed to see out_free, because entry to REQ required ex_ready_o and nothing else loads the register.
- Output holds exToWb_o and ex_valid_o stable while ex_valid_o && !wb_ready_i.
- When wb_ready_i=1 and no new load occurs, ex_valid_o drops next cycle.
- Size is taken from inst[14:12]:
  - Store: 0=SB, 1=SH, 2=SW. wstrb = 4'b0001<<a, 4'b0011<<a, 4'b1111, with a=addr[1:0] (SH uses a[1]*2). wdata is st_data replicated per lane.
  - Load: 0=LB, 1=LH, 2=LW, 4=LBU, 5=LHU. Byte/half is selected by addr[1:0]/addr[1], then sign- or zero-extended.
  - Misaligned access is not trapped; the aligned lane is used.
- ex_fwd_pending_o=1 while state is REQ or WAIT_RSP with a LOAD whose rd_wen=1.
- uop_info (including ebreak, pc, inst) passes through unchanged.
- Simultaneous accept with a wb handshake of the previous output is legal and loses no cycle.

Test Plan:
- ALU burst: opa=7/opb=5 as ADD, SUB, SLT, then opa=0x80000000/opb=4 as SRA, wb_ready_i=1 → ex_valid_o on cycles 1-4 with alu_res 12, 2, 0, 0xF8000000; ex_ready_o stays high.
- Backpressure: wb_ready_i=0 for 3 cycles after an ADD → exToWb_o held, ex_ready_o=0, the next uop is accepted only in the cycle wb_ready_i=1.
- LBU/LB: addr 0x1003, mem_req_ready_i delayed 2 cycles, rdata 0x80AABBCC → mem_req_addr_o=0x1000; LBU gives lsu_res 0x00000080, LB gives 0xFFFFFF80; ex_fwd_pending_o high until the response.
- SH: addr 0x2002, st_data 0x1234 → wstrb 4'b1100, wdata 0x12341234, we=1, ex_valid_o the cycle after the handshake, no response awaited.
- Reset asserted in WAIT_RSP, then a stray mem_rsp_valid_i after release → all outputs 0, no ex_valid_o, state IDLE.
- Forward: ADD writing x5=12 → ex_fwd_valid_o=1, ex_fwd_rd_o=5, ex_fwd_data_o=12 while ex_valid_o=1; a load to x6 drives ex_fwd_data_o=lsu_res.

Source files
------------

// File: rtl/pipe_ex.sv
// pipe_ex_pkg: shared uop and stage-boundary types for the execute stage.
// pipe_ex: execute stage of the in-order pipeline.
//   clk_i / rst_ni        clock (rising edge) and asynchronous active-low reset
//   idToEx_i, id_valid_i  uop offered by decode; ex_ready_o accepts it
//   exToWb_o, ex_valid_o  registered result towards writeback; wb_ready_i accepts it
//   mem_req_*             single-outstanding memory request (word address, lane data, strobes)
//   mem_rsp_*             load data return, only honoured while waiting for it
//   ex_fwd_*              forwarding view of the output uop and an in-flight load marker

package pipe_ex_pkg;
   localparam int ELE_W = 32;
   typedef logic [ELE_W-1:0] ele_t;

   typedef enum logic [1:0] {
      FU_ALU   = 2'd0,
      FU_LOAD  = 2'd1,
      FU_STORE = 2'd2
   } fu_op_e;

   typedef struct packed {
      ele_t        pc;
      ele_t        inst;
      logic [4:0]  rd;
      logic        rd_wen;
      fu_op_e      fu_op;
      logic [3:0]  alu_op;
      logic        ebreak;
   } uop_info_t;

   typedef struct packed {
      uop_info_t uop_info;
      ele_t      opa;
      ele_t      opb;
      ele_t      st_data;
   } idToEx_t;

   typedef struct packed {
      uop_info_t uop_info;
      ele_t      alu_res;
      ele_t      lsu_res;
   } exToWb_t;
endpackage

module pipe_ex
   import pipe_ex_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  idToEx_t         idToEx_i,
   input  logic            id_valid_i,
   output logic            ex_ready_o,
   output exToWb_t         exToWb_o,
   output logic            ex_valid_o,
   input  logic            wb_ready_i,
   output logic            mem_req_valid_o,
   input  logic            mem_req_ready_i,
   output logic            mem_req_we_o,
   output logic [XLEN-1:0] mem_req_addr_o,
   output logic [XLEN-1:0] mem_req_wdata_o,
   output logic [3:0]      mem_req_wstrb_o,
   input  logic            mem_rsp_valid_i,
   input  logic [XLEN-1:0] mem_rsp_rdata_i,
   output logic            ex_fwd_valid_o,
   output logic [4:0]      ex_fwd_rd_o,
   output logic [XLEN-1:0] ex_fwd_data_o,
   output logic            ex_fwd_pending_o
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      REQ      = 2'd1,
      WAIT_RSP = 2'd2
   } state_e;

   state_e    state, state_n;
   uop_info_t info_q;
   ele_t      addr_q;
   ele_t      st_data_q;
   exToWb_t   out_q, out_n;
   logic      out_valid_q;
   logic      out_load;
   logic      out_free;
   logic      accept;
   ele_t      alu_now;
   ele_t      load_data;
   ele_t      byte_word, half_word;
   logic [2:0] size;
   logic [1:0] lane;

   function automatic ele_t alu(input logic [3:0] op, input ele_t a, input ele_t b);
      ele_t r;
      case (op)
         4'd0:    r = a + b;
         4'd1:    r = a - b;
         4'd2:    r = a << b[4:0];
         4'd3:    r = {{(ELE_W-1){1'b0}}, ($signed(a) < $signed(b))};
         4'd4:    r = {{(ELE_W-1){1'b0}}, (a < b)};
         4'd5:    r = a ^ b;
         4'd6:    r = a >> b[4:0];
         4'd7:    r = ele_t'($signed(a) >>> b[4:0]);
         4'd8:    r = a | b;
         4'd9:    r = a & b;
         default: r = '0;
      endcase
      return r;
   endfunction

   // The execute stage only takes a new uop when idle and the output slot is,
   // or is about to be, empty; memory ops are forced to the ADD opcode for address generation.
   always_comb begin
      out_free = !out_valid_q || wb_ready_i;
      ex_ready_o = (state == IDLE) && out_free;
      accept = id_valid_i && ex_ready_o;
      alu_now = alu((idToEx_i.uop_info.fu_op == FU_ALU) ? idToEx_i.uop_info.alu_op : 4'd0,
                    idToEx_i.opa, idToEx_i.opb);
   end

   // Load lane extraction: shift the addressed byte/half down to bit 0, then extend by size.
   always_comb begin
      size = info_q.inst[14:12];
      lane = addr_q[1:0];
      byte_word = mem_rsp_rdata_i >> {lane, 3'b000};
      half_word = mem_rsp_rdata_i >> {lane[1], 4'b0000};
      case (size)
         3'd0:    load_data = {{24{byte_word[7]}}, byte_word[7:0]};
         3'd1:    load_data = {{16{half_word[15]}}, half_word[15:0]};
         3'd4:    load_data = {24'b0, byte_word[7:0]};
         3'd5:    load_data = {16'b0, half_word[15:0]};
         default: load_data = mem_rsp_rdata_i;
      endcase
   end

   // Request side is driven purely from the latched uop, so it stays stable while REQ waits.
   always_comb begin
      mem_req_valid_o = (state == REQ);
      mem_req_we_o = (info_q.fu_op == FU_STORE);
      mem_req_addr_o = {addr_q[XLEN-1:2], 2'b00};
      mem_req_wdata_o = '0;
      mem_req_wstrb_o = 4'b0000;
      if (info_q.fu_op == FU_STORE) begin
         case (size)
            3'd0: begin
               mem_req_wdata_o = {4{st_data_q[7:0]}};
               mem_req_wstrb_o = 4'b0001 << lane;
            end
            3'd1: begin
               mem_req_wdata_o = {2{st_data_q[15:0]}};
               mem_req_wstrb_o = 4'b0011 << {lane[1], 1'b0};
            end
            default: begin
               mem_req_wdata_o = st_data_q;
               mem_req_wstrb_o = 4'b1111;
            end
         endcase
      end
   end

   // Next state and output-register load. ALU uops complete on the accept edge; a store
   // completes on its request handshake and a load on its response.
   always_comb begin
      state_n = state;
      out_load = 1'b0;
      out_n = '0;
      case (state)
         IDLE: begin
            if (accept) begin
               if (idToEx_i.uop_info.fu_op == FU_ALU) begin
                  out_load = out_free;
                  out_n.uop_info = idToEx_i.uop_info;
                  out_n.alu_res = alu_now;
               end else begin
                  state_n = REQ;
               end
            end
         end
         REQ: begin
            if (mem_req_ready_i) begin
               if (info_q.fu_op == FU_STORE) begin
                  state_n = IDLE;
                  out_load = out_free;
                  out_n.uop_info = info_q;
                  out_n.alu_res = addr_q;
               end else begin
                  state_n = WAIT_RSP;
               end
            end
         end
         WAIT_RSP: begin
            if (mem_rsp_valid_i) begin
               state_n = IDLE;
               out_load = out_free;
               out_n.uop_info = info_q;
               out_n.alu_res = addr_q;
               out_n.lsu_res = load_data;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // State, latched uop and the output register; the output holds while wb stalls it.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state <= IDLE;
         info_q <= '0;
         addr_q <= '0;
         st_data_q <= '0;
         out_q <= '0;
         out_valid_q <= 1'b0;
      end else begin
         state <= state_n;
         if (accept) begin
            info_q <= idToEx_i.uop_info;
            addr_q <= alu_now;
            st_data_q <= idToEx_i.st_data;
         end
         if (out_load) begin
            out_q <= out_n;
            out_valid_q <= 1'b1;
         end else if (wb_ready_i) begin
            out_valid_q <= 1'b0;
         end
      end
   end

   // Forwarding: a load's value is only known once its response has landed in the output.
   always_comb begin
      exToWb_o = out_q;
      ex_valid_o = out_valid_q;
      ex_fwd_valid_o = out_valid_q && out_q.uop_info.rd_wen;
      ex_fwd_rd_o = out_q.uop_info.rd;
      ex_fwd_data_o = (out_q.uop_info.fu_op == FU_LOAD) ? out_q.lsu_res : out_q.alu_res;
      ex_fwd_pending_o = ((state == REQ) || (state == WAIT_RSP)) &&
                         (info_q.fu_op == FU_LOAD) && info_q.rd_wen;
   end

endmodule

// File: tb/tb_pipe_ex.sv
// Directed testbench for pipe_ex: reset, ALU burst, backpressure, loads, stores,
// mid-access reset and forwarding, with hand-computed expected values.
module tb_pipe_ex;
   import pipe_ex_pkg::*;

   logic        clk;
   logic        rst_n;
   idToEx_t     id_uop;
   logic        id_valid;
   logic        ex_ready;
   exToWb_t     wb_out;
   logic        ex_valid;
   logic        wb_ready;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [3:0]  req_wstrb;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        fwd_valid;
   logic [4:0]  fwd_rd;
   logic [31:0] fwd_data;
   logic        fwd_pending;

   int vectors = 0;
   int miscompares = 0;

   pipe_ex #(.XLEN(32)) dut (
      .clk_i(clk),
      .rst_ni(rst_n),
      .idToEx_i(id_uop),
      .id_valid_i(id_valid),
      .ex_ready_o(ex_ready),
      .exToWb_o(wb_out),
      .ex_valid_o(ex_valid),
      .wb_ready_i(wb_ready),
      .mem_req_valid_o(req_valid),
      .mem_req_ready_i(req_ready),
      .mem_req_we_o(req_we),
      .mem_req_addr_o(req_addr),
      .mem_req_wdata_o(req_wdata),
      .mem_req_wstrb_o(req_wstrb),
      .mem_rsp_valid_i(rsp_valid),
      .mem_rsp_rdata_i(rsp_rdata),
      .ex_fwd_valid_o(fwd_valid),
      .ex_fwd_rd_o(fwd_rd),
      .ex_fwd_data_o(fwd_data),
      .ex_fwd_pending_o(fwd_pending)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance to just after the next rising edge.
   task automatic step();
      @(posedge clk);
      #2;
   endtask

   function automatic idToEx_t mk(input fu_op_e fu, input logic [3:0] op, input logic [2:0] f3,
                                  input logic [4:0] rd, input logic wen,
                                  input logic [31:0] a, input logic [31:0] b, input logic [31:0] st);
      idToEx_t u;
      u = '0;
      u.uop_info.pc = 32'h0000_0100;
      u.uop_info.inst = {17'b0, f3, 12'b0};
      u.uop_info.rd = rd;
      u.uop_info.rd_wen = wen;
      u.uop_info.fu_op = fu;
      u.uop_info.alu_op = op;
      u.opa = a;
      u.opb = b;
      u.st_data = st;
      return u;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic test_reset();
      #3;
      chk("rst_ex_valid", {31'b0, ex_valid}, 32'd0);
      chk("rst_req_valid", {31'b0, req_valid}, 32'd0);
      chk("rst_fwd_valid", {31'b0, fwd_valid}, 32'd0);
      chk("rst_pending", {31'b0, fwd_pending}, 32'd0);
      chk("rst_alu_res", wb_out.alu_res, 32'd0);
      chk("rst_lsu_res", wb_out.lsu_res, 32'd0);
      step();
      step();
      rst_n = 1'b1;
      #1;
      chk("rst_ready_after", {31'b0, ex_ready}, 32'd1);
      step();
   endtask

   task automatic test_alu_burst();
      logic [31:0] exp_res [4];
      idToEx_t     uops [4];
      uops[0] = mk(FU_ALU, 4'd0, 3'd0, 5'd1, 1'b1, 32'd7, 32'd5, 32'd0);
      uops[1] = mk(FU_ALU, 4'd1, 3'd0, 5'd1, 1'b1, 32'd7, 32'd5, 32'd0);
      uops[2] = mk(FU_ALU, 4'd3, 3'd0, 5'd1, 1'b1, 32'd7, 32'd5, 32'd0);
      uops[3] = mk(FU_ALU, 4'd7, 3'd0, 5'd1, 1'b1, 32'h8000_0000, 32'd4, 32'd0);
      exp_res[0] = 32'd12;
      exp_res[1] = 32'd2;
      exp_res[2] = 32'd0;
      exp_res[3] = 32'hF800_0000;
      wb_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         id_uop = uops[i];
         id_valid = 1'b1;
         #1;
         chk("burst_ready", {31'b0, ex_ready}, 32'd1);
         step();
         chk("burst_valid", {31'b0, ex_valid}, 32'd1);
         chk("burst_res", wb_out.alu_res, exp_res[i]);
      end
      id_valid = 1'b0;
      step();
      chk("burst_drain", {31'b0, ex_valid}, 32'd0);
   endtask

   task automatic test_backpressure();
      wb_ready = 1'b0;
      id_uop = mk(FU_ALU, 4'd0, 3'd0, 5'd2, 1'b1, 32'd1, 32'd2, 32'd0);
      id_valid = 1'b1;
      step();
      id_uop = mk(FU_ALU, 4'd5, 3'd0, 5'd3, 1'b1, 32'd6, 32'd3, 32'd0);
      #1;
      chk("bp_valid", {31'b0, ex_valid}, 32'd1);
      chk("bp_res", wb_out.alu_res, 32'd3);
      chk("bp_ready_low", {31'b0, ex_ready}, 32'd0);
      for (int i = 0; i < 2; i++) begin
         step();
         chk("bp_hold_valid", {31'b0, ex_valid}, 32'd1);
         chk("bp_hold_res", wb_out.alu_res, 32'd3);
         chk("bp_hold_rd", {27'b0, wb_out.uop_info.rd}, 32'd2);
         chk("bp_hold_ready", {31'b0, ex_ready}, 32'd0);
      end
      wb_ready = 1'b1;
      #1;
      chk("bp_release_ready", {31'b0, ex_ready}, 32'd1);
      step();
      id_valid = 1'b0;
      chk("bp_next_valid", {31'b0, ex_valid}, 32'd1);
      chk("bp_next_res", wb_out.alu_res, 32'd5);
      step();
      chk("bp_drain", {31'b0, ex_valid}, 32'd0);
   endtask

   task automatic test_load(input logic [2:0] f3, input logic [31:0] exp);
      wb_ready = 1'b1;
      req_ready = 1'b0;
      id_uop = mk(FU_LOAD, 4'd0, f3, 5'd6, 1'b1, 32'h0000_1000, 32'd3, 32'd0);
      id_valid = 1'b1;
      step();
      id_valid = 1'b0;
      #1;
      chk("ld_req_valid", {31'b0, req_valid}, 32'd1);
      chk("ld_addr", req_addr, 32'h0000_1000);
      chk("ld_we", {31'b0, req_we}, 32'd0);
      chk("ld_pending_req", {31'b0, fwd_pending}, 32'd1);
      chk("ld_ready_low", {31'b0, ex_ready}, 32'd0);
      step();
      chk("ld_req_hold", {31'b0, req_valid}, 32'd1);
      chk("ld_addr_hold", req_addr, 32'h0000_1000);
      req_ready = 1'b1;
      step();
      req_ready = 1'b0;
      #1;
      chk("ld_req_done", {31'b0, req_valid}, 32'd0);
      chk("ld_pending_wait", {31'b0, fwd_pending}, 32'd1);
      chk("ld_no_valid", {31'b0, ex_valid}, 32'd0);
      step();
      rsp_valid = 1'b1;
      rsp_rdata = 32'h80AA_BBCC;
      step();
      rsp_valid = 1'b0;
      rsp_rdata = 32'd0;
      #1;
      chk("ld_valid", {31'b0, ex_valid}, 32'd1);
      chk("ld_lsu_res", wb_out.lsu_res, exp);
      chk("ld_pending_done", {31'b0, fwd_pending}, 32'd0);
      chk("ld_fwd_valid", {31'b0, fwd_valid}, 32'd1);
      chk("ld_fwd_rd", {27'b0, fwd_rd}, 32'd6);
      chk("ld_fwd_data", fwd_data, exp);
      step();
      chk("ld_drain", {31'b0, ex_valid}, 32'd0);
   endtask

   task automatic test_store();
      wb_ready = 1'b1;
      req_ready = 1'b0;
      id_uop = mk(FU_STORE, 4'd0, 3'd1, 5'd0, 1'b0, 32'h0000_2000, 32'd2, 32'h0000_1234);
      id_valid = 1'b1;
      step();
      id_valid = 1'b0;
      #1;
      chk("st_req_valid", {31'b0, req_valid}, 32'd1);
      chk("st_we", {31'b0, req_we}, 32'd1);
      chk("st_addr", req_addr, 32'h0000_2000);
      chk("st_wstrb", {28'b0, req_wstrb}, 32'h0000_000C);
      chk("st_wdata", req_wdata, 32'h1234_1234);
      chk("st_pending", {31'b0, fwd_pending}, 32'd0);
      req_ready = 1'b1;
      step();
      req_ready = 1'b0;
      #1;
      chk("st_valid", {31'b0, ex_valid}, 32'd1);
      chk("st_alu_res", wb_out.alu_res, 32'h0000_2002);
      chk("st_req_done", {31'b0, req_valid}, 32'd0);
      chk("st_idle_ready", {31'b0, ex_ready}, 32'd1);
      step();
      chk("st_drain", {31'b0, ex_valid}, 32'd0);
   endtask

   task automatic test_reset_mid();
      wb_ready = 1'b1;
      id_uop = mk(FU_LOAD, 4'd0, 3'd2, 5'd7, 1'b1, 32'h0000_3000, 32'd0, 32'd0);
      id_valid = 1'b1;
      req_ready = 1'b1;
      step();
      id_valid = 1'b0;
      step();
      req_ready = 1'b0;
      #1;
      chk("rm_in_wait", {31'b0, fwd_pending}, 32'd1);
      rst_n = 1'b0;
      #1;
      chk("rm_req_valid", {31'b0, req_valid}, 32'd0);
      chk("rm_pending", {31'b0, fwd_pending}, 32'd0);
      chk("rm_ex_valid", {31'b0, ex_valid}, 32'd0);
      step();
      rst_n = 1'b1;
      rsp_valid = 1'b1;
      rsp_rdata = 32'hDEAD_BEEF;
      step();
      rsp_valid = 1'b0;
      #1;
      chk("rm_stray_valid", {31'b0, ex_valid}, 32'd0);
      chk("rm_stray_lsu", wb_out.lsu_res, 32'd0);
      chk("rm_idle_ready", {31'b0, ex_ready}, 32'd1);
      chk("rm_fwd_valid", {31'b0, fwd_valid}, 32'd0);
      step();
      chk("rm_still_idle", {31'b0, ex_valid}, 32'd0);
   endtask

   task automatic test_forward();
      wb_ready = 1'b1;
      id_uop = mk(FU_ALU, 4'd0, 3'd0, 5'd5, 1'b1, 32'd7, 32'd5, 32'd0);
      id_uop.uop_info.pc = 32'h0000_0ABC;
      id_uop.uop_info.ebreak = 1'b1;
      id_valid = 1'b1;
      step();
      id_valid = 1'b0;
      #1;
      chk("fwd_valid", {31'b0, fwd_valid}, 32'd1);
      chk("fwd_rd", {27'b0, fwd_rd}, 32'd5);
      chk("fwd_data", fwd_data, 32'd12);
      chk("fwd_pc", wb_out.uop_info.pc, 32'h0000_0ABC);
      chk("fwd_ebreak", {31'b0, wb_out.uop_info.ebreak}, 32'd1);
      step();
      chk("fwd_drop", {31'b0, fwd_valid}, 32'd0);
   endtask

   initial begin
      rst_n = 1'b0;
      id_uop = '0;
      id_valid = 1'b0;
      wb_ready = 1'b0;
      req_ready = 1'b0;
      rsp_valid = 1'b0;
      rsp_rdata = '0;
      test_reset();
      test_alu_burst();
      test_backpressure();
      test_load(3'd4, 32'h0000_0080);
      test_load(3'd0, 32'hFFFF_FF80);
      test_store();
      test_reset_mid();
      test_forward();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
